// File: rtl/ext_irq_arb_pkg.sv
// ext_irq_arb_pkg
// Shared types and constants for the external-interrupt arbiter slice.
//   NUM_W        width of a source number, fixed by the interrupt controller
//   arb_state_t  arbiter FSM states (IDLE, REQ, RECOVER)
//   irq_level_t  2-bit source priority, 3 is the most urgent
//   cfg_entry_t  one row of the per-source configuration table
package ext_irq_arb_pkg;

  localparam int NUM_W = 6;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    RECOVER = 2'd2
  } arb_state_t;

  typedef logic [1:0] irq_level_t;

  typedef struct packed {
    logic       enable;
    irq_level_t level;
  } cfg_entry_t;

endpackage

// File: rtl/ext_irq_arb_pick.sv
// ext_irq_arb_pick
// Purely combinational winner selection among eligible IRQ sources.
// The winner is the eligible source with the highest level. Ties go to the
// lowest index by default; with EXT_IRQ_ARB_ROUND_ROBIN_EN defined they go to
// the first tied source found searching upward (with wrap) from start_idx.
// Ports:
//   eligible   in   N_SRC        pending & enabled sources
//   level_vec  in   N_SRC x 2    configured level per source
//   start_idx  in   NUM_W        round-robin search start (macro builds only)
//   valid      out  1            at least one source is eligible
//   index      out  NUM_W        selected source index (0 when not valid)
module ext_irq_arb_pick
  import ext_irq_arb_pkg::*;
#(
  parameter int N_SRC = 16
)
(
  input  logic                   eligible [N_SRC],
  input  irq_level_t             level_vec [N_SRC],
`ifdef EXT_IRQ_ARB_ROUND_ROBIN_EN
  input  logic [NUM_W-1:0]       start_idx,
`endif
  output logic                   valid,
  output logic [NUM_W-1:0]       index
);

  irq_level_t best_level;

  // Find the highest level present among the eligible sources.
  always_comb begin
    best_level = '0;
    valid      = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (eligible[i]) begin
        valid = 1'b1;
        if (level_vec[i] > best_level) begin
          best_level = level_vec[i];
        end
      end
    end
  end

`ifdef EXT_IRQ_ARB_ROUND_ROBIN_EN
  // Among sources at the winning level, pick the one closest to start_idx
  // going upward with wrap; distance is computed per index so every array
  // access uses a constant subscript.
  always_comb begin
    int best_dist;
    int dist;
    best_dist = N_SRC;
    dist      = 0;
    index     = '0;
    for (int i = 0; i < N_SRC; i++) begin
      dist = i - int'(start_idx);
      if (dist < 0) begin
        dist = dist + N_SRC;
      end
      if (eligible[i] && (level_vec[i] == best_level) && (dist < best_dist)) begin
        best_dist = dist;
        index     = NUM_W'(i);
      end
    end
  end
`else
  // Among sources at the winning level, the lowest index wins; scanning
  // downward lets the last assignment be the lowest match.
  always_comb begin
    index = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i] && (level_vec[i] == best_level)) begin
        index = NUM_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/ext_irq_arbiter.sv
// ext_irq_arbiter
// Shares the interrupt controller's single external-interrupt input among
// N_SRC device IRQ lines. Rising request edges become pending bits, one
// winner is chosen by configured level and presented to the controller,
// held stable until acknowledged, then retired with a one-cycle ack pulse
// back to the device.
// Optional build macro: EXT_IRQ_ARB_ROUND_ROBIN_EN (round-robin tie-break).
// Ports:
//   iCLOCK        in   1      clock
//   iRESET_SYNC   in   1      synchronous active-high reset
//   iIRQ_REQ      in   N_SRC  device request levels, rising edge -> pending
//   oIRQ_SRC_ACK  out  N_SRC  one-hot one-cycle retire pulse to the device
//   iCFG_VALID    in   1      config table write strobe
//   iCFG_ENTRY    in   6      source index to write (>= N_SRC ignored)
//   iCFG_ENABLE   in   1      source enable
//   iCFG_LEVEL    in   2      source level, 3 highest
//   oEXT_ACTIVE   out  1      request to the interrupt controller
//   oEXT_NUM      out  NUM_W  granted source index
//   iEXT_ACK      in   1      accept pulse from the interrupt controller
//   oPENDING      out  N_SRC  pending vector readback
//   oBUSY         out  1      high in REQ and RECOVER
module ext_irq_arbiter
  import ext_irq_arb_pkg::*;
#(
  parameter int N_SRC = 16
)
(
  input  logic                iCLOCK,
  input  logic                iRESET_SYNC,
  input  logic [N_SRC-1:0]    iIRQ_REQ,
  output logic [N_SRC-1:0]    oIRQ_SRC_ACK,
  input  logic                iCFG_VALID,
  input  logic [NUM_W-1:0]    iCFG_ENTRY,
  input  logic                iCFG_ENABLE,
  input  irq_level_t          iCFG_LEVEL,
  output logic                oEXT_ACTIVE,
  output logic [NUM_W-1:0]    oEXT_NUM,
  input  logic                iEXT_ACK,
  output logic [N_SRC-1:0]    oPENDING,
  output logic                oBUSY
);

  arb_state_t          state;
  logic [N_SRC-1:0]    req_sampled;
  logic [N_SRC-1:0]    req_prev;
  logic [N_SRC-1:0]    pending;
  logic [N_SRC-1:0]    rise;
  logic [N_SRC-1:0]    clear_mask;
  cfg_entry_t          cfg_tbl [N_SRC];
  logic                eligible [N_SRC];
  irq_level_t          level_vec [N_SRC];
  logic                grant_done;
  logic                pick_valid;
  logic [NUM_W-1:0]    pick_index;

  assign oPENDING   = pending;
  assign grant_done = (state == REQ) && iEXT_ACK;
  assign rise       = req_sampled & ~req_prev;

  // Two-stage history: req_sampled is the current sample, req_prev the one
  // before it, so a low-to-high sample sets pending one edge later.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      req_sampled <= '0;
      req_prev    <= '0;
    end else begin
      req_sampled <= iIRQ_REQ;
      req_prev    <= req_sampled;
    end
  end

  // The retiring source's bit, only in the cycle the controller accepts.
  always_comb begin
    clear_mask = '0;
    for (int i = 0; i < N_SRC; i++) begin
      clear_mask[i] = grant_done && (oEXT_NUM == NUM_W'(i));
    end
  end

  // Pending bits: a new edge wins over a same-cycle retire so a device that
  // re-requests exactly at ack time is not lost.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clear_mask) | rise;
    end
  end

  // Configuration table; out-of-range entries match no row and are dropped.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      for (int i = 0; i < N_SRC; i++) begin
        cfg_tbl[i].enable <= 1'b1;
        cfg_tbl[i].level  <= '0;
      end
    end else if (iCFG_VALID) begin
      for (int i = 0; i < N_SRC; i++) begin
        if (iCFG_ENTRY == NUM_W'(i)) begin
          cfg_tbl[i].enable <= iCFG_ENABLE;
          cfg_tbl[i].level  <= iCFG_LEVEL;
        end
      end
    end
  end

  // Disabled sources keep their pending bit but are hidden from the picker.
  always_comb begin
    for (int i = 0; i < N_SRC; i++) begin
      eligible[i]  = pending[i] & cfg_tbl[i].enable;
      level_vec[i] = cfg_tbl[i].level;
    end
  end

`ifdef EXT_IRQ_ARB_ROUND_ROBIN_EN
  logic [NUM_W-1:0] last_grant;
  logic [NUM_W-1:0] rr_start;

  // The search begins just past the most recently retired source; reset to
  // the top index so the very first search starts at source 0.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      last_grant <= NUM_W'(N_SRC - 1);
    end else if (grant_done) begin
      last_grant <= oEXT_NUM;
    end
  end

  assign rr_start = (last_grant == NUM_W'(N_SRC - 1)) ? '0 : last_grant + 1'b1;

  ext_irq_arb_pick #(.N_SRC(N_SRC)) u_pick (
    .eligible  (eligible),
    .level_vec (level_vec),
    .start_idx (rr_start),
    .valid     (pick_valid),
    .index     (pick_index)
  );
`else
  ext_irq_arb_pick #(.N_SRC(N_SRC)) u_pick (
    .eligible  (eligible),
    .level_vec (level_vec),
    .valid     (pick_valid),
    .index     (pick_index)
  );
`endif

  // Grant FSM with registered outputs. The number is latched only in IDLE,
  // so later arrivals or config changes never disturb a grant in flight.
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state        <= IDLE;
      oEXT_ACTIVE  <= 1'b0;
      oEXT_NUM     <= '0;
      oIRQ_SRC_ACK <= '0;
      oBUSY        <= 1'b0;
    end else begin
      oIRQ_SRC_ACK <= '0;
      unique case (state)
        IDLE: begin
          if (pick_valid) begin
            oEXT_NUM    <= pick_index;
            oEXT_ACTIVE <= 1'b1;
            oBUSY       <= 1'b1;
            state       <= REQ;
          end
        end
        REQ: begin
          if (iEXT_ACK) begin
            oIRQ_SRC_ACK <= clear_mask;
            oEXT_ACTIVE  <= 1'b0;
            state        <= RECOVER;
          end
        end
        RECOVER: begin
          oBUSY <= 1'b0;
          state <= IDLE;
        end
        default: begin
          oEXT_ACTIVE <= 1'b0;
          oBUSY       <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ext_irq_arbiter.sv
// tb_ext_irq_arbiter
// Directed self-checking bench for ext_irq_arbiter with N_SRC=16.
// Inputs change 1 time unit after each rising clock edge; outputs are
// checked at that same point, reflecting the registers updated by the edge.
module tb_ext_irq_arbiter;

  logic        iCLOCK;
  logic        iRESET_SYNC;
  logic [15:0] iIRQ_REQ;
  logic [15:0] oIRQ_SRC_ACK;
  logic        iCFG_VALID;
  logic [5:0]  iCFG_ENTRY;
  logic        iCFG_ENABLE;
  logic [1:0]  iCFG_LEVEL;
  logic        oEXT_ACTIVE;
  logic [5:0]  oEXT_NUM;
  logic        iEXT_ACK;
  logic [15:0] oPENDING;
  logic        oBUSY;

  int checks;
  int failures;
  int expOrder [4];

  ext_irq_arbiter #(.N_SRC(16)) dut (
    .iCLOCK       (iCLOCK),
    .iRESET_SYNC  (iRESET_SYNC),
    .iIRQ_REQ     (iIRQ_REQ),
    .oIRQ_SRC_ACK (oIRQ_SRC_ACK),
    .iCFG_VALID   (iCFG_VALID),
    .iCFG_ENTRY   (iCFG_ENTRY),
    .iCFG_ENABLE  (iCFG_ENABLE),
    .iCFG_LEVEL   (iCFG_LEVEL),
    .oEXT_ACTIVE  (oEXT_ACTIVE),
    .oEXT_NUM     (oEXT_NUM),
    .iEXT_ACK     (iEXT_ACK),
    .oPENDING     (oPENDING),
    .oBUSY        (oBUSY)
  );

  initial iCLOCK = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  // Hard time limit so a stuck run still terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive request lines and ack, then advance past one rising edge.
  task automatic applyStimulus(input logic [15:0] req, input logic ack);
    iIRQ_REQ = req;
    iEXT_ACK = ack;
    @(posedge iCLOCK);
    #1;
  endtask

  task automatic writeCfg(input logic [5:0] entry, input logic en, input logic [1:0] lvl);
    iCFG_VALID  = 1'b1;
    iCFG_ENTRY  = entry;
    iCFG_ENABLE = en;
    iCFG_LEVEL  = lvl;
    applyStimulus(16'h0000, 1'b0);
    iCFG_VALID  = 1'b0;
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    iRESET_SYNC = 1'b1;
    iIRQ_REQ    = '0;
    iEXT_ACK    = 1'b0;
    iCFG_VALID  = 1'b0;
    iCFG_ENTRY  = '0;
    iCFG_ENABLE = 1'b0;
    iCFG_LEVEL  = '0;
`ifdef EXT_IRQ_ARB_ROUND_ROBIN_EN
    expOrder = '{1, 2, 3, 1};
`else
    expOrder = '{1, 1, 1, 1};
`endif

    applyStimulus(16'h0000, 1'b0);
    applyStimulus(16'h0000, 1'b0);
    checkOutput("rst active", oEXT_ACTIVE, 0);
    checkOutput("rst num", oEXT_NUM, 0);
    checkOutput("rst srcack", oIRQ_SRC_ACK, 0);
    checkOutput("rst pending", oPENDING, 0);
    checkOutput("rst busy", oBUSY, 0);
    iRESET_SYNC = 1'b0;
    applyStimulus(16'h0000, 1'b0);

    $display("[TB] test 1: single source 5");
    applyStimulus(16'h0020, 1'b0);
    checkOutput("t1 pending early", oPENDING, 16'h0000);
    applyStimulus(16'h0000, 1'b0);
    checkOutput("t1 pending set", oPENDING, 16'h0020);
    checkOutput("t1 active early", oEXT_ACTIVE, 0);
    applyStimulus(16'h0000, 1'b0);
    checkOutput("t1 active", oEXT_ACTIVE, 1);
    checkOutput("t1 num", oEXT_NUM, 5);
    checkOutput("t1 busy", oBUSY, 1);
    applyStimulus(16'h0000, 1'b1);
    checkOutput("t1 srcack", oIRQ_SRC_ACK, 16'h0020);
    checkOutput("t1 pending clr", oPENDING, 16'h0000);
    checkOutput("t1 recover active", oEXT_ACTIVE, 0);
    checkOutput("t1 recover busy", oBUSY, 1);
    applyStimulus(16'h0000, 1'b0);
    checkOutput("t1 srcack pulse", oIRQ_SRC_ACK, 16'h0000);
    checkOutput("t1 idle busy", oBUSY, 0);

    $display("[TB] test 2: level priority");
    writeCfg(6'd3, 1'b1, 2'd2);
    writeCfg(6'd9, 1'b1, 2'd3);
    applyStimulus(16'h0208, 1'b0);
    applyStimulus(16'h0000, 1'b0);
    applyStimulus(16'h0000, 1'b0);
    checkOutput("t2 active", oEXT_ACTIVE, 1);
    checkOutput("t2 num first", oEXT_NUM, 9);
    applyStimulus(16'h0000, 1'b1);
    checkOutput("t2 srcack 9", oIRQ_SRC_ACK, 16'h0200);
    checkOutput("t2 pending left", oPENDING, 16'h0008);
    applyStimulus(16'h0000, 1'b0);
    checkOutput("t2 gap active", oEXT_ACTIVE, 0);
    applyStimulus(16'h0000, 1'b0);
    checkOutput("t2 second active", oEXT_ACTIVE, 1);
    checkOutput("t2 num second", oEXT_NUM, 3);
    applyStimulus(16'h0000, 1'b1);
    checkOutput("t2 srcack 3", oIRQ_SRC_ACK, 16'h0008);
    applyStimulus(16'h0000, 1'b0);

    $display("[TB] test 3: no re-arbitration during REQ");
    writeCfg(6'd7, 1'b1, 2'd3);
    applyStimulus(16'h0004, 1'b0);
    applyStimulus(16'h0000, 1'b0);
    applyStimulus(16'h0000, 1'b0);
    checkOutput("t3 num 2", oEXT_NUM, 2);
    applyStimulus(16'h0080, 1'b0);
    applyStimulus(16'h0000, 1'b0);
    applyStimulus(16'h0000, 1'b0);
    checkOutput("t3 num held", oEXT_NUM, 2);
    checkOutput("t3 active held", oEXT_ACTIVE, 1);
    checkOutput("t3 pending both", oPENDING, 16'h0084);
    applyStimulus(16'h0000, 1'b1);
    checkOutput("t3 srcack 2", oIRQ_SRC_ACK, 16'h0004);
    applyStimulus(16'h0000, 1'b0);
    applyStimulus(16'h0000, 1'b0);
    checkOutput("t3 num 7", oEXT_NUM, 7);
    checkOutput("t3 active 7", oEXT_ACTIVE, 1);
    applyStimulus(16'h0000, 1'b1);
    applyStimulus(16'h0000, 1'b0);

    $display("[TB] test 4: enable handling");
    writeCfg(6'd16, 1'b0, 2'd0);
    applyStimulus(16'h0001, 1'b0);
    applyStimulus(16'h0000, 1'b0);
    applyStimulus(16'h0000, 1'b0);
    checkOutput("t4 entry16 ignored", oEXT_ACTIVE, 1);
    checkOutput("t4 num 0", oEXT_NUM, 0);
    applyStimulus(16'h0000, 1'b1);
    applyStimulus(16'h0000, 1'b0);
    writeCfg(6'd4, 1'b0, 2'd0);
    applyStimulus(16'h0010, 1'b0);
    applyStimulus(16'h0000, 1'b0);
    applyStimulus(16'h0010, 1'b0);
    applyStimulus(16'h0000, 1'b0);
    applyStimulus(16'h0000, 1'b0);
    checkOutput("t4 disabled active", oEXT_ACTIVE, 0);
    checkOutput("t4 disabled pending", oPENDING, 16'h0010);
    applyStimulus(16'h0000, 1'b1);
    checkOutput("t4 stray ack pending", oPENDING, 16'h0010);
    checkOutput("t4 stray ack srcack", oIRQ_SRC_ACK, 16'h0000);
    checkOutput("t4 stray ack busy", oBUSY, 0);
    writeCfg(6'd4, 1'b1, 2'd0);
    checkOutput("t4 enable latency", oEXT_ACTIVE, 0);
    applyStimulus(16'h0000, 1'b0);
    checkOutput("t4 reenabled active", oEXT_ACTIVE, 1);
    checkOutput("t4 num 4", oEXT_NUM, 4);
    writeCfg(6'd4, 1'b0, 2'd0);
    checkOutput("t4 disable in REQ", oEXT_ACTIVE, 1);
    checkOutput("t4 num kept", oEXT_NUM, 4);
    applyStimulus(16'h0000, 1'b1);
    checkOutput("t4 srcack 4", oIRQ_SRC_ACK, 16'h0010);
    applyStimulus(16'h0000, 1'b0);
    writeCfg(6'd4, 1'b1, 2'd0);

    $display("[TB] test 5: set wins over clear, reset in REQ");
    applyStimulus(16'h0040, 1'b0);
    applyStimulus(16'h0000, 1'b0);
    applyStimulus(16'h0000, 1'b0);
    checkOutput("t5 num 6", oEXT_NUM, 6);
    applyStimulus(16'h0040, 1'b0);
    applyStimulus(16'h0000, 1'b1);
    checkOutput("t5 pending kept", oPENDING, 16'h0040);
    checkOutput("t5 srcack 6", oIRQ_SRC_ACK, 16'h0040);
    applyStimulus(16'h0000, 1'b0);
    applyStimulus(16'h0000, 1'b0);
    checkOutput("t5 regrant active", oEXT_ACTIVE, 1);
    checkOutput("t5 regrant num", oEXT_NUM, 6);
    iRESET_SYNC = 1'b1;
    applyStimulus(16'h0000, 1'b0);
    checkOutput("t5 rst active", oEXT_ACTIVE, 0);
    checkOutput("t5 rst pending", oPENDING, 16'h0000);
    checkOutput("t5 rst srcack", oIRQ_SRC_ACK, 16'h0000);
    checkOutput("t5 rst busy", oBUSY, 0);
    iRESET_SYNC = 1'b0;
    applyStimulus(16'h0000, 1'b0);
    checkOutput("t5 post rst srcack", oIRQ_SRC_ACK, 16'h0000);

    $display("[TB] test 6: equal-level tie-break");
    applyStimulus(16'h000E, 1'b0);
    applyStimulus(16'h0000, 1'b0);
    applyStimulus(16'h0000, 1'b0);
    for (int k = 0; k < 4; k++) begin
      checkOutput("t6 active", oEXT_ACTIVE, 1);
      checkOutput("t6 grant order", oEXT_NUM, expOrder[k]);
      applyStimulus(16'(1 << expOrder[k]), 1'b0);
      applyStimulus(16'h0000, 1'b1);
      applyStimulus(16'h0000, 1'b0);
      applyStimulus(16'h0000, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
